// File: rtl/keypad_scanner.sv
// ---- keypad_scanner: 4x5 key-matrix column scanner with press/release debounce ----
// ---- Rev 1.0 ----
`default_nettype none

module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [4:0] col_drv,
  output logic [2:0] key_row,
  output logic [2:0] key_col,
  output logic       key_valid,
  output logic       key_press,
  output logic       key_release
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] c_dwell_last = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_cnt_done   = CW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_SCAN     = 2'd0,
    S_DEBOUNCE = 2'd1,
    S_HELD     = 2'd2,
    S_RELEASE  = 2'd3
  } state_t;

  logic [3:0]    r_sync1, r_sync2;
  logic [DW-1:0] r_dwell;
  state_t        r_state, w_state_nxt;
  logic [2:0]    r_col, w_col_nxt;
  logic [1:0]    r_cand_row, w_cand_row_nxt;
  logic [2:0]    r_cand_col, w_cand_col_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_key_row, w_key_row_nxt;
  logic [2:0]    r_key_col, w_key_col_nxt;
  logic          r_key_valid, w_key_valid_nxt;
  logic          r_key_press, w_key_press_nxt;
  logic          r_key_release, w_key_release_nxt;

  logic          w_sample;
  logic          w_any_low;
  logic          w_cand_high;
  logic [1:0]    w_win_row;
  logic [CW-1:0] w_cnt_inc;
  logic [2:0]    w_col_adv;

  // Rows idle high, so the synchronizer resets to "no key".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
      r_dwell <= '0;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
      r_dwell <= w_sample ? '0 : r_dwell + DW'(1);
    end
  end

  assign w_sample    = (r_dwell == c_dwell_last);
  assign w_any_low   = ~&r_sync2;
  assign w_cand_high = r_sync2[r_cand_row];
  assign w_cnt_inc   = r_cnt + CW'(1);
  assign w_col_adv   = (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;

  always_comb begin
    w_win_row = 2'd0;
    if      (!r_sync2[0]) w_win_row = 2'd0;
    else if (!r_sync2[1]) w_win_row = 2'd1;
    else if (!r_sync2[2]) w_win_row = 2'd2;
    else if (!r_sync2[3]) w_win_row = 2'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_SCAN;
      r_col         <= 3'd0;
      r_cand_row    <= 2'd0;
      r_cand_col    <= 3'd0;
      r_cnt         <= '0;
      r_key_row     <= 3'd0;
      r_key_col     <= 3'd0;
      r_key_valid   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_col         <= w_col_nxt;
      r_cand_row    <= w_cand_row_nxt;
      r_cand_col    <= w_cand_col_nxt;
      r_cnt         <= w_cnt_nxt;
      r_key_row     <= w_key_row_nxt;
      r_key_col     <= w_key_col_nxt;
      r_key_valid   <= w_key_valid_nxt;
      r_key_press   <= w_key_press_nxt;
      r_key_release <= w_key_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_col_nxt         = r_col;
    w_cand_row_nxt    = r_cand_row;
    w_cand_col_nxt    = r_cand_col;
    w_cnt_nxt         = r_cnt;
    w_key_row_nxt     = r_key_row;
    w_key_col_nxt     = r_key_col;
    w_key_valid_nxt   = r_key_valid;
    w_key_press_nxt   = 1'b0;
    w_key_release_nxt = 1'b0;
    if (w_sample) begin
      case (r_state)
        S_SCAN: begin
          if (w_any_low) begin
            w_cand_row_nxt = w_win_row;
            w_cand_col_nxt = r_col;
            w_cnt_nxt      = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              w_key_row_nxt   = {1'b0, w_win_row} + 3'd1;
              w_key_col_nxt   = r_col + 3'd1;
              w_key_valid_nxt = 1'b1;
              w_key_press_nxt = 1'b1;
              w_state_nxt     = S_HELD;
            end else begin
              w_state_nxt = S_DEBOUNCE;
            end
          end else begin
            w_col_nxt = w_col_adv;
          end
        end
        S_DEBOUNCE: begin
          if (!w_cand_high) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == c_cnt_done) begin
              w_key_row_nxt   = {1'b0, r_cand_row} + 3'd1;
              w_key_col_nxt   = r_cand_col + 3'd1;
              w_key_valid_nxt = 1'b1;
              w_key_press_nxt = 1'b1;
              w_state_nxt     = S_HELD;
            end
          end else begin
            w_col_nxt   = w_col_adv;
            w_state_nxt = S_SCAN;
          end
        end
        S_HELD: begin
          if (w_cand_high) begin
            w_cnt_nxt = CW'(1);
            if (DEBOUNCE_SCANS == 1) begin
              w_key_row_nxt     = 3'd0;
              w_key_col_nxt     = 3'd0;
              w_key_valid_nxt   = 1'b0;
              w_key_release_nxt = 1'b1;
              w_col_nxt         = w_col_adv;
              w_state_nxt       = S_SCAN;
            end else begin
              w_state_nxt = S_RELEASE;
            end
          end
        end
        S_RELEASE: begin
          if (w_cand_high) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == c_cnt_done) begin
              w_key_row_nxt     = 3'd0;
              w_key_col_nxt     = 3'd0;
              w_key_valid_nxt   = 1'b0;
              w_key_release_nxt = 1'b1;
              w_col_nxt         = w_col_adv;
              w_state_nxt       = S_SCAN;
            end
          end else begin
            w_state_nxt = S_HELD;
          end
        end
        default: w_state_nxt = S_SCAN;
      endcase
    end
  end

  always_comb begin
    case (r_col)
      3'd0:    col_drv = 5'b11110;
      3'd1:    col_drv = 5'b11101;
      3'd2:    col_drv = 5'b11011;
      3'd3:    col_drv = 5'b10111;
      default: col_drv = 5'b01111;
    endcase
  end

  assign key_row     = r_key_row;
  assign key_col     = r_key_col;
  assign key_valid   = r_key_valid;
  assign key_press   = r_key_press;
  assign key_release = r_key_release;

endmodule

`default_nettype wire

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: key-matrix model drives the rows; a rule-level model predicts every output each cycle.
`default_nettype none

module tb_keypad_scanner;

  localparam int SD = 4;
  localparam int DS = 3;
  localparam int M_SCAN = 0, M_DEB = 1, M_HELD = 2, M_REL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] row_in;
  logic [4:0] col_drv;
  logic [2:0] key_row, key_col;
  logic       key_valid, key_press, key_release;

  bit key_m [4][5];

  int n_checks = 0;
  int n_fail   = 0;
  int n_press  = 0;
  int n_rel    = 0;

  int       m_col, m_dwell, m_mode, m_cnt, m_crow, m_ccol, m_krow, m_kcol;
  bit       m_valid, m_press, m_rel;
  logic [3:0] m_s1, m_s2;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_drv(col_drv),
    .key_row(key_row), .key_col(key_col), .key_valid(key_valid),
    .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Physical matrix: a pressed key shorts its row to its column while that column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (key_m[r][c] && !col_drv[c]) row_in[r] = 1'b0;
  end

  function automatic logic [3:0] matrix_view(input int col);
    logic [3:0] v;
    v = 4'hF;
    for (int r = 0; r < 4; r++) if (key_m[r][col]) v[r] = 1'b0;
    return v;
  endfunction

  task automatic model_reset();
    m_col = 0; m_dwell = 0; m_mode = M_SCAN; m_cnt = 0; m_crow = 0; m_ccol = 0;
    m_krow = 0; m_kcol = 0; m_valid = 0; m_press = 0; m_rel = 0;
    m_s1 = 4'hF; m_s2 = 4'hF;
  endtask

  task automatic do_accept();
    m_krow = m_crow + 1; m_kcol = m_ccol + 1; m_valid = 1; m_press = 1; m_mode = M_HELD;
  endtask

  task automatic do_release();
    m_krow = 0; m_kcol = 0; m_valid = 0; m_rel = 1; m_col = (m_col + 1) % 5; m_mode = M_SCAN;
  endtask

  task automatic model_step();
    logic [3:0] rs;
    bit smp;
    rs = m_s2; m_s2 = m_s1; m_s1 = matrix_view(m_col);
    smp = (m_dwell == SD - 1);
    m_dwell = (m_dwell + 1) % SD;
    m_press = 0; m_rel = 0;
    if (smp) begin
      case (m_mode)
        M_SCAN:
          if (rs != 4'hF) begin
            for (int r = 3; r >= 0; r--) if (!rs[r]) m_crow = r;
            m_ccol = m_col; m_cnt = 1;
            if (m_cnt == DS) do_accept(); else m_mode = M_DEB;
          end else m_col = (m_col + 1) % 5;
        M_DEB:
          if (!rs[m_crow]) begin
            m_cnt++;
            if (m_cnt == DS) do_accept();
          end else begin
            m_mode = M_SCAN; m_col = (m_col + 1) % 5;
          end
        M_HELD:
          if (rs[m_crow]) begin
            m_cnt = 1;
            if (m_cnt == DS) do_release(); else m_mode = M_REL;
          end
        default:
          if (rs[m_crow]) begin
            m_cnt++;
            if (m_cnt == DS) do_release();
          end else m_mode = M_HELD;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_cycle();
    logic [4:0]  ec;
    logic [13:0] e, a;
    ec = ~(5'b00001 << m_col);
    e = {ec, 3'(m_krow), 3'(m_kcol), m_valid, m_press, m_rel};
    a = {col_drv, key_row, key_col, key_valid, key_press, key_release};
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL cycle at %0t: dut col=%b row=%0d col=%0d v=%b p=%b r=%b, model col=%b row=%0d col=%0d v=%b p=%b r=%b",
               $time, a[13:9], a[8:6], a[5:3], a[2], a[1], a[0],
               e[13:9], e[8:6], e[5:3], e[2], e[1], e[0]);
    end
    if (key_press === 1'b1) n_press++;
    if (key_release === 1'b1) n_rel++;
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
    cmp_cycle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++) for (int c = 0; c < 5; c++) key_m[r][c] = 0;
  endtask

  task automatic wait_valid(input logic v, input int budget, input string name);
    int n;
    n = 0;
    while (key_valid !== v && n < budget) begin tick(); n++; end
    n_checks++;
    if (key_valid !== v) begin
      n_fail++;
      $display("FAIL %s: timeout, key_valid=%b expected %b", name, key_valid, v);
    end
  endtask

  task automatic wait_release_pulse(input int budget, input string name);
    int n;
    n = 0;
    while (key_release !== 1'b1 && n < budget) begin tick(); n++; end
    n_checks++;
    if (key_release !== 1'b1) begin
      n_fail++;
      $display("FAIL %s: timeout, key_release=%b expected 1", name, key_release);
    end
  endtask

  task automatic wait_mode(input int mode, input int budget, input string name);
    int n;
    n = 0;
    while (m_mode != mode && n < budget) begin tick(); n++; end
    n_checks++;
    if (m_mode != mode) begin
      n_fail++;
      $display("FAIL %s: timeout, model mode=%0d expected %0d", name, m_mode, mode);
    end
  endtask

  initial begin
    int p0, r0, nk, hold, gap;
    clear_keys();
    model_reset();
    ticks(3);
    #2 rst_n = 1'b1;
    chk("reset_col_drv", 32'(col_drv), 32'h1E);
    chk("reset_key_valid", 32'(key_valid), 32'h0);

    // Free-running scan: one column per SD cycles, wrapping after column 5.
    ticks(4);
    chk("scan_col2", 32'(col_drv), 32'h1D);
    ticks(16);
    chk("scan_wrap_col1", 32'(col_drv), 32'h1E);
    chk("scan_no_key", 32'({key_row, key_col, key_valid}), 32'h0);

    // Steady key row 2 / column 3.
    p0 = n_press;
    key_m[1][2] = 1;
    wait_valid(1'b1, 200, "hold_r2c3");
    chk("hold_key_row", 32'(key_row), 32'd2);
    chk("hold_key_col", 32'(key_col), 32'd3);
    ticks(20);
    chk("hold_col_frozen", 32'(col_drv), 32'h1B);
    chk("hold_one_press", 32'(n_press - p0), 32'd1);
    clear_keys();
    wait_valid(1'b0, 100, "release_r2c3");

    // Bounce: seen low on one column-3 sample, high on the next.
    p0 = n_press;
    key_m[1][2] = 1;
    wait_mode(M_DEB, 200, "bounce_enter");
    clear_keys();
    wait_mode(M_SCAN, 20, "bounce_discard");
    chk("bounce_next_col4", 32'(col_drv), 32'h17);
    ticks(30);
    chk("bounce_no_press", 32'(n_press - p0), 32'd0);

    // Rows 1 and 4 together in column 5: lowest row wins.
    key_m[0][4] = 1;
    key_m[3][4] = 1;
    wait_valid(1'b1, 200, "multi_row");
    chk("multi_key_row", 32'(key_row), 32'd1);
    chk("multi_key_col", 32'(key_col), 32'd5);
    r0 = n_rel;
    clear_keys();
    wait_release_pulse(100, "multi_release");
    chk("release_col1", 32'(col_drv), 32'h1E);
    chk("release_clear", 32'({key_row, key_col, key_valid}), 32'h0);
    chk("release_one_pulse", 32'(n_rel - r0), 32'd1);

    // Held key (4,1) with a single high glitch sample.
    key_m[3][0] = 1;
    wait_valid(1'b1, 200, "glitch_press");
    r0 = n_rel;
    ticks(2);
    while (m_dwell != 0) tick();
    key_m[3][0] = 0;
    ticks(4);
    key_m[3][0] = 1;
    ticks(20);
    chk("glitch_valid", 32'(key_valid), 32'd1);
    chk("glitch_row_col", 32'({key_row, key_col}), 32'({3'd4, 3'd1}));
    chk("glitch_no_release", 32'(n_rel - r0), 32'd0);
    clear_keys();
    wait_valid(1'b0, 100, "glitch_final_release");

    // Reset while key (3,5) is valid.
    key_m[2][4] = 1;
    wait_valid(1'b1, 200, "rst_press");
    r0 = n_rel;
    #2 rst_n = 1'b0;
    model_reset();
    #1 cmp_cycle();
    chk("rst_outputs_clear", 32'({col_drv, key_row, key_col, key_valid, key_press, key_release}),
        32'({5'b11110, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0}));
    ticks(3);
    #2 rst_n = 1'b1;
    p0 = n_press;
    wait_valid(1'b1, 200, "rst_reaccept");
    chk("rst_reaccept_rc", 32'({key_row, key_col}), 32'({3'd3, 3'd5}));
    chk("rst_fresh_press", 32'(n_press - p0), 32'd1);
    chk("rst_no_release", 32'(n_rel - r0), 32'd0);
    clear_keys();
    wait_valid(1'b0, 100, "rst_final_release");

    // Randomized presses, holds, bounces and multi-key chords.
    for (int it = 0; it < 40; it++) begin
      nk = $urandom_range(1, 2);
      for (int k = 0; k < nk; k++) key_m[$urandom_range(0, 3)][$urandom_range(0, 4)] = 1;
      hold = $urandom_range(1, 70);
      gap  = $urandom_range(1, 60);
      ticks(hold);
      clear_keys();
      ticks(gap);
    end
    ticks(100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
